// File: rtl/mux8_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux8_rr_arbiter_if
//  Brief    : Requester/consumer handshake bundle around the 8-way arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] req_mask;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic [7:0] ack;
    logic       busy;

    // master: requester/consumer side; slave: the arbiter itself
    modport master (
        output req, req_mask, out_ready,
        input  sel, grant, out_valid, ack, busy
    );

    modport slave (
        input  req, req_mask, out_ready,
        output sel, grant, out_valid, ack, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux8_rr_arbiter
//  Brief    : Round-robin arbiter with bounded bursts driving an 8:1 mux select.
//  Revision : 1.0  initial release
// ============================================================================
module mux8_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    mux8_rr_arbiter_if.slave     bus
);

    localparam logic [0:0]       c_IDLE  = 1'b0;
    localparam logic [0:0]       c_GRANT = 1'b1;
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(MAX_BURST - 1);

    logic [0:0]       r_state;
    logic [7:0]       r_grant;
    logic [2:0]       r_sel;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic [0:0]       w_state_nxt;
    logic [7:0]       w_grant_nxt;
    logic [2:0]       w_sel_nxt;
    logic [2:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [7:0]       w_elig;
    logic [15:0]      w_dbl;
    logic [7:0]       w_rot;
    logic [2:0]       w_k;
    logic [2:0]       w_winner;
    logic             w_busy;
    logic             w_out_valid;
    logic             w_xfer;
    logic             w_release;

    // Rotate the eligible set so bit 0 is the pointer position; the lowest
    // set bit of the rotated vector is then the round-robin winner.
    assign w_elig   = bus.req & bus.req_mask;
    assign w_dbl    = {w_elig, w_elig};
    assign w_rot    = w_dbl[r_ptr +: 8];
    assign w_winner = r_ptr + w_k;

    always_comb begin
        w_k = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_k = 3'(i);
            end
        end
    end

    assign w_busy      = (r_state == c_GRANT);
    assign w_out_valid = w_busy & bus.req[r_sel];
    assign w_xfer      = w_out_valid & bus.out_ready;
    assign w_release   = (w_xfer && (r_cnt == c_LAST)) || !bus.req[r_sel];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_grant <= 8'h00;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_elig != 8'h00) begin
                    w_state_nxt = c_GRANT;
                    w_grant_nxt = 8'b1 << w_winner;
                    w_sel_nxt   = w_winner;
                    w_cnt_nxt   = '0;
                end
            end
            c_GRANT: begin
                if (w_release) begin
                    w_state_nxt = c_IDLE;
                    w_grant_nxt = 8'h00;
                    w_ptr_nxt   = r_sel + 3'd1;
                    w_cnt_nxt   = '0;
                end else if (w_xfer) begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_grant_nxt = 8'h00;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.sel       = r_sel;
        bus.grant     = r_grant;
        bus.busy      = w_busy;
        bus.out_valid = w_out_valid;
        bus.ack       = r_grant & bus.req & {8{bus.out_ready}};
    end

endmodule
`default_nettype wire
